// File: rtl/avalon_st_sink_skid.sv
// Avalon-ST sink front end: 2-entry skid buffer with a registered ready_out, plus a frame length meter.
// Optional framing check is enabled by defining PKT_CHECK_EN.
module avalon_st_sink_skid #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 20,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  output logic              ready_out,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              startofpacket_in,
  input  logic              endofpacket_in,
  input  logic              ready_in,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic              startofpacket_out,
  output logic              endofpacket_out,
  output logic [LEN_W-1:0]  frame_len,
  output logic              frame_done,
  output logic              frame_err,
  output logic [ERR_W-1:0]  err_cnt
);

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [DATA_W-1:0] data;
  } beat_t;

  function automatic logic [LEN_W-1:0] len_sat_inc(input logic [LEN_W-1:0] v);
    return (&v) ? v : v + LEN_W'(1);
  endfunction

  function automatic logic [ERR_W-1:0] err_sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  beat_t in_beat;
  beat_t o_beat_q, o_beat_d;
  beat_t s_beat_q, s_beat_d;
  logic  o_vld_q, o_vld_d;
  logic  s_vld_q, s_vld_d;
  logic  rdy_q, rdy_d;
  logic  accept, xfer, o_free;

  assign in_beat = '{sop: startofpacket_in, eop: endofpacket_in, data: data_in};
  assign accept  = valid_in & rdy_q;
  assign xfer    = o_vld_q & ready_in;
  assign o_free  = ~o_vld_q | xfer;

  // S is only ever occupied while ready_out is low, so S draining and a new accept never coincide.
  always_comb begin
    o_vld_d  = o_vld_q;
    o_beat_d = o_beat_q;
    s_vld_d  = s_vld_q;
    s_beat_d = s_beat_q;
    if (s_vld_q) begin
      if (o_free) begin
        o_vld_d  = 1'b1;
        o_beat_d = s_beat_q;
        s_vld_d  = 1'b0;
      end
    end else if (accept) begin
      if (o_free) begin
        o_vld_d  = 1'b1;
        o_beat_d = in_beat;
      end else begin
        s_vld_d  = 1'b1;
        s_beat_d = in_beat;
      end
    end else if (xfer) begin
      o_vld_d = 1'b0;
    end
    rdy_d = ~s_vld_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_vld_q  <= 1'b0;
      o_beat_q <= '0;
      s_vld_q  <= 1'b0;
      s_beat_q <= '0;
      rdy_q    <= 1'b0;
    end else begin
      o_vld_q  <= o_vld_d;
      o_beat_q <= o_beat_d;
      s_vld_q  <= s_vld_d;
      s_beat_q <= s_beat_d;
      rdy_q    <= rdy_d;
    end
  end

  assign ready_out         = rdy_q;
  assign valid_out         = o_vld_q;
  assign data_out          = o_beat_q.data;
  assign startofpacket_out = o_beat_q.sop;
  assign endofpacket_out   = o_beat_q.eop;

  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             in_pkt_q, in_pkt_d;
  logic             done_q, done_d;

  // A stray non-SOP beat outside a packet is forwarded but neither counted nor able to close a frame.
  always_comb begin
    cnt_d    = cnt_q;
    len_d    = len_q;
    in_pkt_d = in_pkt_q;
    done_d   = 1'b0;
    if (accept) begin
      if (startofpacket_in) begin
        cnt_d    = LEN_W'(1);
        in_pkt_d = 1'b1;
      end else if (in_pkt_q) begin
        cnt_d = len_sat_inc(cnt_q);
      end
      if (endofpacket_in && (in_pkt_q || startofpacket_in)) begin
        len_d    = cnt_d;
        done_d   = 1'b1;
        in_pkt_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      len_q    <= '0;
      in_pkt_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      in_pkt_q <= in_pkt_d;
      done_q   <= done_d;
    end
  end

  assign frame_len  = len_q;
  assign frame_done = done_q;

`ifdef PKT_CHECK_EN
  logic             pkt_err;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  assign pkt_err = accept & (startofpacket_in ? in_pkt_q : ~in_pkt_q);

  always_comb begin
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (pkt_err) begin
      err_d     = 1'b1;
      err_cnt_d = err_sat_inc(err_cnt_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign frame_err = err_q;
  assign err_cnt   = err_cnt_q;
`else
  assign frame_err = 1'b0;
  assign err_cnt   = '0;
`endif

endmodule
